mcpu_ctrl_fsm: RTL and testbench

Multi-cycle control unit that sequences the MCPU datapath (PC, instruction register, 16-entry register file, ALU, multi-cycle divider, 256-word RAM). It holds the instruction register, decodes the 4-bit opcode and drives every datapath enable and select. It also owns the divider start/done handshake, halt/fault detection and a retired-instruction counter. It sits inside MCPU between the RAM read port and the PC/regfile/ALU.

---
 rtl/mcpu_pkg.sv | 49 ++++
 rtl/mcpu_ctrl_fsm_if.sv | 42 ++++
 rtl/mcpu_ctrl_decode.sv | 55 +++++
 rtl/mcpu_ctrl_fsm.sv | 128 ++++++++++++
 tb/tb_mcpu_ctrl_fsm.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mcpu_pkg.sv
// Shared MCPU definitions: field widths, opcodes, writeback selects,
// control-FSM states and the datapath control bundle.
package mcpu_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int OPCODE_SIZE = 4;
    localparam int IMM_SIZE    = 8;

    localparam logic [OPCODE_SIZE-1:0] OP_AND           = 4'd0;
    localparam logic [OPCODE_SIZE-1:0] OP_OR            = 4'd1;
    localparam logic [OPCODE_SIZE-1:0] OP_XOR           = 4'd2;
    localparam logic [OPCODE_SIZE-1:0] OP_ADD           = 4'd3;
    localparam logic [OPCODE_SIZE-1:0] OP_MUL           = 4'd4;
    localparam logic [OPCODE_SIZE-1:0] OP_DIV           = 4'd5;
    localparam logic [OPCODE_SIZE-1:0] OP_SHORT_TO_REG  = 4'd6;
    localparam logic [OPCODE_SIZE-1:0] OP_LOAD_FROM_MEM = 4'd7;
    localparam logic [OPCODE_SIZE-1:0] OP_STORE_TO_MEM  = 4'd8;
    localparam logic [OPCODE_SIZE-1:0] OP_BNZ           = 4'd9;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_IMM = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;
    localparam logic [1:0] WB_DIV = 2'd3;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        EXEC     = 3'd2,
        MEM      = 3'd3,
        DIV_WAIT = 3'd4,
        HALT     = 3'd5
    } state_t;

    typedef struct packed {
        logic       mem_addr_sel;
        logic       mem_we;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       pc_inc;
        logic       pc_load;
        logic       div_start;
    } ctrl_t;

    // Opcodes above BNZ are unassigned and stop the core.
    function automatic logic is_illegal(input logic [OPCODE_SIZE-1:0] op);
        return op > OP_BNZ;
    endfunction

endpackage

// File: rtl/mcpu_ctrl_fsm_if.sv
// Control-unit <-> datapath bundle. The control unit is the master; the
// datapath (RAM, regfile, ALU, divider, PC) is the slave.
interface mcpu_ctrl_fsm_if #(
    parameter int CNT_WIDTH = 16
);
    import mcpu_pkg::*;

    logic [WORD_SIZE-1:0]   mem_rdata;
    logic                   rf_zero;
    logic                   div_done;
    logic                   mem_addr_sel;
    logic                   mem_we;
    logic [OPCODE_SIZE-1:0] ir_opcode;
    logic [OPCODE_SIZE-1:0] ir_rd;
    logic [OPCODE_SIZE-1:0] ir_rs;
    logic [OPCODE_SIZE-1:0] ir_rt;
    logic [IMM_SIZE-1:0]    ir_imm;
    logic                   rf_we;
    logic [1:0]             wb_sel;
    logic [OPCODE_SIZE-1:0] alu_op;
    logic                   pc_inc;
    logic                   pc_load;
    logic                   div_start;
    logic                   halted;
    logic                   fault;
    logic [CNT_WIDTH-1:0]   instr_count;

    modport master (
        input  mem_rdata, rf_zero, div_done,
        output mem_addr_sel, mem_we, ir_opcode, ir_rd, ir_rs, ir_rt, ir_imm,
               rf_we, wb_sel, alu_op, pc_inc, pc_load, div_start,
               halted, fault, instr_count
    );

    modport slave (
        output mem_rdata, rf_zero, div_done,
        input  mem_addr_sel, mem_we, ir_opcode, ir_rd, ir_rs, ir_rt, ir_imm,
               rf_we, wb_sel, alu_op, pc_inc, pc_load, div_start,
               halted, fault, instr_count
    );

endinterface

// File: rtl/mcpu_ctrl_decode.sv
// Combinational decode of (state, opcode, rf_zero) into datapath enables.
// DIV_WAIT writeback depends on div_done and is added by the parent.
module mcpu_ctrl_decode
    import mcpu_pkg::*;
(
    input  state_t                 state,
    input  logic [OPCODE_SIZE-1:0] opcode,
    input  logic                   rf_zero,
    output ctrl_t                  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.pc_inc = 1'b1;
            end
            DECODE: begin
                ctrl.div_start = (opcode == OP_DIV);
            end
            EXEC: begin
                case (opcode)
                    OP_AND, OP_OR, OP_XOR, OP_ADD, OP_MUL: begin
                        ctrl.rf_we  = 1'b1;
                        ctrl.wb_sel = WB_ALU;
                    end
                    OP_SHORT_TO_REG: begin
                        ctrl.rf_we  = 1'b1;
                        ctrl.wb_sel = WB_IMM;
                    end
                    OP_STORE_TO_MEM: begin
                        ctrl.mem_addr_sel = 1'b1;
                        ctrl.mem_we       = 1'b1;
                    end
                    OP_BNZ: begin
                        ctrl.pc_load = !rf_zero;
                    end
                    // Present the load address one cycle early so RAM data is
                    // ready for writeback in MEM.
                    OP_LOAD_FROM_MEM: begin
                        ctrl.mem_addr_sel = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                ctrl.mem_addr_sel = 1'b1;
                ctrl.rf_we        = 1'b1;
                ctrl.wb_sel       = WB_MEM;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// MCPU multi-cycle control unit: instruction register, sequencing FSM,
// divider timeout, sticky halt/fault and retired-instruction counter.
module mcpu_ctrl_fsm
    import mcpu_pkg::*;
#(
    parameter int DIV_MAX_CYCLES = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic             clk,
    input  logic             reset,
    mcpu_ctrl_fsm_if.master  bus
);

    localparam int TIMER_W = (DIV_MAX_CYCLES > 2) ? $clog2(DIV_MAX_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DIV_MAX_CYCLES - 1);

    state_t                 state_reg, state_next;
    logic [WORD_SIZE-1:0]   ir_reg;
    logic [TIMER_W-1:0]     timer_reg;
    logic [CNT_WIDTH-1:0]   count_reg;
    logic                   halted_reg;
    logic                   fault_reg;
    logic                   halt_set;
    logic                   fault_set;
    logic                   retire;
    logic [OPCODE_SIZE-1:0] opcode;
    ctrl_t                  dec_ctrl;
    ctrl_t                  ctrl_out;

    assign opcode = ir_reg[WORD_SIZE-1 -: OPCODE_SIZE];

    mcpu_ctrl_decode u_decode (
        .state   (state_reg),
        .opcode  (opcode),
        .rf_zero (bus.rf_zero),
        .ctrl    (dec_ctrl)
    );

    always_comb begin
        state_next = state_reg;
        halt_set   = 1'b0;
        fault_set  = 1'b0;
        case (state_reg)
            FETCH:  state_next = DECODE;
            DECODE: begin
                if (is_illegal(opcode)) begin
                    state_next = HALT;
                    halt_set   = 1'b1;
                end else if (opcode == OP_DIV) begin
                    state_next = DIV_WAIT;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC:   state_next = (opcode == OP_LOAD_FROM_MEM) ? MEM : FETCH;
            MEM:    state_next = FETCH;
            // A result arriving on the last allowed cycle still counts.
            DIV_WAIT: begin
                if (bus.div_done) begin
                    state_next = FETCH;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next = HALT;
                    halt_set   = 1'b1;
                    fault_set  = 1'b1;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    assign retire = (state_next == FETCH) &&
                    ((state_reg == EXEC) || (state_reg == MEM) || (state_reg == DIV_WAIT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= FETCH;
            ir_reg     <= '0;
            timer_reg  <= '0;
            count_reg  <= '0;
            halted_reg <= 1'b0;
            fault_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == FETCH) begin
                ir_reg <= bus.mem_rdata;
            end
            timer_reg <= (state_reg == DIV_WAIT && !bus.div_done) ? timer_reg + 1'b1 : '0;
            if (retire && (count_reg != '1)) begin
                count_reg <= count_reg + 1'b1;
            end
            halted_reg <= halted_reg | halt_set;
            fault_reg  <= fault_reg | fault_set;
        end
    end

    // Enables are forced low while reset is held so an aborted instruction
    // cannot write back on the reset edge.
    always_comb begin
        ctrl_out = dec_ctrl;
        if (state_reg == DIV_WAIT && bus.div_done) begin
            ctrl_out.rf_we  = 1'b1;
            ctrl_out.wb_sel = WB_DIV;
        end
        if (!reset) begin
            ctrl_out = '0;
        end
    end

    assign bus.mem_addr_sel = ctrl_out.mem_addr_sel;
    assign bus.mem_we       = ctrl_out.mem_we;
    assign bus.rf_we        = ctrl_out.rf_we;
    assign bus.wb_sel       = ctrl_out.wb_sel;
    assign bus.pc_inc       = ctrl_out.pc_inc;
    assign bus.pc_load      = ctrl_out.pc_load;
    assign bus.div_start    = ctrl_out.div_start;

    assign bus.ir_opcode   = opcode;
    assign bus.ir_rd       = ir_reg[11:8];
    assign bus.ir_rs       = ir_reg[7:4];
    assign bus.ir_rt       = ir_reg[3:0];
    assign bus.ir_imm      = ir_reg[IMM_SIZE-1:0];
    assign bus.alu_op      = opcode;
    assign bus.halted      = halted_reg;
    assign bus.fault       = fault_reg;
    assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Randomized bench for mcpu_ctrl_fsm: per-instruction cycle timelines from a
// behavioural model, checked every cycle on the falling edge.
module tb_mcpu_ctrl_fsm;

    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   n_instr;

    int   m_count;
    logic m_halted;
    logic m_fault;

    mcpu_ctrl_fsm_if #(.CNT_WIDTH(CW)) bus ();

    mcpu_ctrl_fsm #(
        .DIV_MAX_CYCLES (32),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s instr=%0d got=%h exp=%h", tag, n_instr, got, exp);
        end
    endtask

    // {mem_addr_sel, mem_we, rf_we, wb_sel, pc_inc, pc_load, div_start, halted, fault}
    function automatic logic [9:0] ctl(input logic ms, input logic mw, input logic rw,
                                       input logic [1:0] wb, input logic pi,
                                       input logic pl, input logic ds);
        return {ms, mw, rw, wb, pi, pl, ds, m_halted, m_fault};
    endfunction

    function automatic logic [31:0] irvec();
        return {4'h0, bus.ir_opcode, bus.ir_rd, bus.ir_rs, bus.ir_rt, bus.ir_imm, bus.alu_op};
    endfunction

    // Drive one cycle's inputs, check outputs at the falling edge, then step.
    task automatic tick(input string tag, input logic [15:0] rdata, input logic rfz,
                        input logic dd, input logic [9:0] exp_ctl);
        logic [9:0] obs;
        bus.mem_rdata = rdata;
        bus.rf_zero   = rfz;
        bus.div_done  = dd;
        @(negedge clk);
        obs = {bus.mem_addr_sel, bus.mem_we, bus.rf_we, bus.wb_sel, bus.pc_inc,
               bus.pc_load, bus.div_start, bus.halted, bus.fault};
        chk(tag, {14'h0, obs, bus.instr_count}, {14'h0, exp_ctl, 8'(m_count)});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick("reset", 16'($urandom), 1'($urandom), 1'($urandom), ctl(0, 0, 0, 2'd0, 0, 0, 0));
        m_halted = 1'b0;
        m_fault  = 1'b0;
        m_count  = 0;
        reset    = 1'b1;
        chk("ir_after_reset", irvec(), 32'h0);
    endtask

    task automatic hold_halt(input int n);
        for (int i = 0; i < n; i++) begin
            tick("halt_idle", 16'($urandom), 1'($urandom), 1'($urandom), ctl(0, 0, 0, 2'd0, 0, 0, 0));
        end
    endtask

    // dlat: DIV_WAIT cycle (1-based) that carries div_done; >32 means it never comes.
    task automatic run_instr(input logic [15:0] w, input logic rfz, input int dlat);
        logic [3:0] op;
        op = w[15:12];
        n_instr++;
        $display("instr %0d word=%h op=%0d rf_zero=%0d div_lat=%0d count=%0d",
                 n_instr, w, op, rfz, dlat, m_count);
        tick("fetch", w, 1'($urandom), 1'($urandom), ctl(0, 0, 0, 2'd0, 1, 0, 0));
        tick("decode", 16'($urandom), 1'($urandom), 1'($urandom),
             ctl(0, 0, 0, 2'd0, 0, 0, op == 4'd5));
        if (op > 4'd9) begin
            m_halted = 1'b1;
            return;
        end
        chk("ir_fields", irvec(), {4'h0, w[15:12], w[11:8], w[7:4], w[3:0], w[7:0], w[15:12]});
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4:
                tick("exec_alu", 16'($urandom), 1'($urandom), 1'($urandom), ctl(0, 0, 1, 2'd0, 0, 0, 0));
            4'd6:
                tick("exec_imm", 16'($urandom), 1'($urandom), 1'($urandom), ctl(0, 0, 1, 2'd1, 0, 0, 0));
            4'd8:
                tick("exec_store", 16'($urandom), 1'($urandom), 1'($urandom), ctl(1, 1, 0, 2'd0, 0, 0, 0));
            4'd9:
                tick("exec_bnz", 16'($urandom), rfz, 1'($urandom), ctl(0, 0, 0, 2'd0, 0, !rfz, 0));
            4'd7: begin
                tick("exec_load", 16'($urandom), 1'($urandom), 1'($urandom), ctl(1, 0, 0, 2'd0, 0, 0, 0));
                tick("mem_load", 16'($urandom), 1'($urandom), 1'($urandom), ctl(1, 0, 1, 2'd2, 0, 0, 0));
            end
            default: begin
                for (int k = 0; k < 32; k++) begin
                    if (k == dlat - 1) begin
                        tick("div_done", 16'($urandom), 1'($urandom), 1'b1, ctl(0, 0, 1, 2'd3, 0, 0, 0));
                        break;
                    end
                    tick("div_wait", 16'($urandom), 1'($urandom), 1'b0, ctl(0, 0, 0, 2'd0, 0, 0, 0));
                end
                if (dlat > 32) begin
                    m_halted = 1'b1;
                    m_fault  = 1'b1;
                    return;
                end
            end
        endcase
        if (m_count < CNT_MAX) m_count++;
    endtask

    function automatic logic [15:0] rand_word(input logic allow_illegal);
        logic [3:0] op;
        if (allow_illegal && $urandom_range(0, 15) == 0) op = 4'($urandom_range(10, 15));
        else op = 4'($urandom_range(0, 9));
        return {op, 12'($urandom)};
    endfunction

    initial begin
        logic [15:0] w;
        n_checks = 0;
        n_fail   = 0;
        n_instr  = 0;
        m_count  = 0;
        m_halted = 1'b0;
        m_fault  = 1'b0;
        reset        = 1'b0;
        bus.mem_rdata = '0;
        bus.rf_zero   = 1'b0;
        bus.div_done  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed walk through each instruction class.
        run_instr({4'd6, 4'd9, 8'h20}, 1'b0, 1);
        chk("count_after_short", 32'(bus.instr_count), 32'd1);
        run_instr({4'd7, 4'd0, 8'h64}, 1'b0, 1);
        run_instr({4'd9, 4'd3, 8'h17}, 1'b0, 1);
        run_instr({4'd9, 4'd3, 8'h17}, 1'b1, 1);
        run_instr({4'd5, 4'd6, 4'd0, 4'd7}, 1'b0, 5);
        run_instr({4'd3, 4'd1, 4'd2, 4'd3}, 1'b0, 1);
        run_instr({4'd5, 4'd6, 4'd0, 4'd7}, 1'b0, 32);
        run_instr({4'd5, 4'd2, 4'd4, 4'd5}, 1'b0, 99);
        hold_halt(100);
        do_reset();
        run_instr({4'd2, 4'd1, 4'd1, 4'd1}, 1'b0, 1);
        run_instr(16'hF123, 1'b0, 1);
        hold_halt(5);
        do_reset();

        // Reset landing in the EXEC cycle of an ADD.
        tick("fetch_add", {4'd3, 4'd4, 4'd5, 4'd6}, 1'b0, 1'b0, ctl(0, 0, 0, 2'd0, 1, 0, 0));
        tick("decode_add", 16'($urandom), 1'b0, 1'b0, ctl(0, 0, 0, 2'd0, 0, 0, 0));
        do_reset();

        // Long legal stream drives the 8-bit counter into saturation.
        for (int i = 0; i < 300; i++) begin
            run_instr(rand_word(1'b0), 1'($urandom), $urandom_range(1, 32));
        end
        chk("count_saturated", 32'(bus.instr_count), 32'(CNT_MAX));

        // Mixed stream including illegal opcodes and divider timeouts.
        for (int i = 0; i < 300; i++) begin
            w = rand_word(1'b1);
            run_instr(w, 1'($urandom), $urandom_range(1, 36));
            if (m_halted) begin
                hold_halt($urandom_range(1, 6));
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
